// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the fabric-to-PowerPC OPB register.
// Holds register offsets, bit positions, bus FSM states and limits.
package opb_s2p_pkg;

    // Word offsets taken from OPB_ABus[24:29]
    localparam logic [5:0] OFF_DATA    = 6'd0;
    localparam logic [5:0] OFF_STATUS  = 6'd1;
    localparam logic [5:0] OFF_CONTROL = 6'd2;
    localparam logic [5:0] OFF_SEQNUM  = 6'd3;

    localparam int STAT_NEW_BIT    = 0;
    localparam int STAT_OVR_LSB    = 8;
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLR_BIT    = 1;

    localparam logic [7:0] OVR_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        DONE
    } bus_state_t;

endpackage

// File: rtl/opb_s2p_bus_fsm.sv
// OPB slave decode, three-state handshake FSM and read-data gating.
// Exactly one ack per select; Sl_DBus is zero outside the ack cycle.
module opb_s2p_bus_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_3700,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_37FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] abus,
    input  logic [0:31] dbus,
    input  logic        rnw,
    input  logic        select,
    input  logic [31:0] rd_mux,
    output logic [5:0]  addr_off,
    output logic [5:0]  off_q,
    output logic [31:0] wr_data,
    output logic        rd_en,
    output logic        wr_en,
    output logic [31:0] sl_dbus,
    output logic        xfer_ack
);

    bus_state_t  state;
    bus_state_t  next_state;
    logic        hit;
    logic        rnw_q;
    logic [31:0] data_q;
    logic        unused_ok;

    assign hit       = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign addr_off  = abus[24:29];
    assign unused_ok = ^abus[30:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            off_q   <= '0;
            rnw_q   <= 1'b0;
            wr_data <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && hit) begin
                data_q  <= rd_mux;
                off_q   <= addr_off;
                rnw_q   <= rnw;
                wr_data <= dbus;
            end
        end
    end

    always_comb begin
        next_state = state;
        xfer_ack   = 1'b0;
        unique case (state)
            IDLE: if (hit) next_state = ACK;
            ACK: begin
                xfer_ack   = 1'b1;
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign rd_en   = xfer_ack & rnw_q;
    assign wr_en   = xfer_ack & ~rnw_q;
    assign sl_dbus = xfer_ack ? data_q : 32'h0;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC OPB register: capture, status, overrun and freeze.
// Define OPB_S2P_SEQNUM_EN to add a capture sequence counter at 0x0C.
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_3700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_37FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic        Sl_xferAck,
    input  logic [31:0] user_data_in,
    input  logic        user_data_valid
);

    logic [5:0]  addr_off;
    logic [5:0]  off_q;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rd_mux;
    logic [31:0] sl_dbus;
    logic [31:0] seq_val;

    logic [31:0] data_reg;
    logic        new_flag;
    logic [7:0]  ovr_cnt;
    logic        freeze;

    logic        cap;
    logic        data_clr;
    logic        ctrl_wr;
    logic        ovr_clr;
    logic        unused_ok;

    assign unused_ok = ^{OPB_BE, OPB_seqAddr};

    opb_s2p_bus_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_bus (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .abus     (OPB_ABus),
        .dbus     (OPB_DBus),
        .rnw      (OPB_RNW),
        .select   (OPB_select),
        .rd_mux   (rd_mux),
        .addr_off (addr_off),
        .off_q    (off_q),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .sl_dbus  (sl_dbus),
        .xfer_ack (Sl_xferAck)
    );

    assign Sl_DBus    = sl_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign cap      = user_data_valid & ~freeze;
    assign data_clr = rd_en & (off_q == OFF_DATA);
    assign ctrl_wr  = wr_en & (off_q == OFF_CONTROL);
    assign ovr_clr  = ctrl_wr & wr_data[CTRL_CLR_BIT];

    // A capture beats a same-cycle DATA read: flag stays, no overrun
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_reg <= '0;
            new_flag <= 1'b0;
            ovr_cnt  <= '0;
            freeze   <= 1'b0;
        end else begin
            if (cap) data_reg <= user_data_in;
            if (cap)           new_flag <= 1'b1;
            else if (data_clr) new_flag <= 1'b0;
            if (ovr_clr)
                ovr_cnt <= '0;
            else if (cap && new_flag && !data_clr && ovr_cnt != OVR_MAX)
                ovr_cnt <= ovr_cnt + 8'd1;
            if (ctrl_wr) freeze <= wr_data[CTRL_FREEZE_BIT];
        end
    end

`ifdef OPB_S2P_SEQNUM_EN
    logic [31:0] seq_cnt;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) seq_cnt <= '0;
        else if (cap) seq_cnt <= seq_cnt + 32'd1;
    end

    assign seq_val = seq_cnt;
`else
    assign seq_val = 32'h0;
`endif

    always_comb begin
        rd_mux = 32'h0;
        unique case (1'b1)
            (addr_off == OFF_DATA): rd_mux = data_reg;
            (addr_off == OFF_STATUS): begin
                rd_mux[STAT_NEW_BIT]                  = new_flag;
                rd_mux[STAT_OVR_LSB +: 8]             = ovr_cnt;
            end
            (addr_off == OFF_CONTROL): rd_mux[CTRL_FREEZE_BIT] = freeze;
            (addr_off == OFF_SEQNUM):  rd_mux = seq_val;
            default: rd_mux = 32'h0;
        endcase
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
Name: opb_register_simulink2ppc

Overview:
OPB slave register that carries data in the opposite direction to the PPC-to-fabric control registers. Fabric logic presents a 32-bit word with a valid strobe; the block captures it, and the PowerPC reads it over OPB. Status and control words give a new-data flag, an overrun counter and a freeze control. It sits on the shared OPB bus beside the other software registers in the XPS base system.

Parameters:
- C_BASEADDR, 32'h01003700: first byte address of the 256-byte window.
- C_HIGHADDR, 32'h010037FF: last byte address of the window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width; only 32 is supported.
- C_FAMILY, "virtex5": target family; informational only.

Ports:
- OPB_Clk  in  1  sole clock; user side is synchronous to it.
- OPB_Rst  in  1  synchronous active-high reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transaction valid.
- OPB_seqAddr  in  1  burst hint; ignored.
- Sl_DBus  out  [0:31]  read data; must be zero whenever Sl_xferAck is low (OR-bus).
- Sl_errAck  out  1  constant 0.
- Sl_retry  out  1  constant 0.
- Sl_toutSup  out  1  constant 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_in  in  [31:0]  fabric data.
- user_data_valid  in  1  capture strobe, one cycle per word.

Behaviour:
- Hit decode: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Word offset is OPB_ABus[24:29]:
  - 0x00 DATA, read-only.
  - 0x04 STATUS, read-only: bit0 = new flag; bits15:8 = overrun count; other bits 0.
  - 0x08 CONTROL: bit0 = freeze (read/write); bit1 = clear overrun (write 1, self-clearing, reads 0).
  - All other offsets read 0; writes to them are acked and ignored.
- Writes to DATA and STATUS are acked with no effect. OPB_BE is ignored; all writes are full-word.
- Bus FSM states IDLE, ACK, DONE:
  - IDLE -> ACK on a hit. The read mux output is registered in this cycle.
  - ACK: Sl_xferAck=1 and Sl_DBus = registered value for one cycle. Write side effects apply in this cycle. Always -> DONE.
  - DONE: no ack, one cycle. -> IDLE. This guarantees exactly one ack per select and no double ack while the master drops select.
  - Latency: select at cycle N gives xferAck at N+1.
- Capture, when user_data_valid=1:
  - freeze=0: data_reg <= user_data_in. If the new flag is already 1, the overrun count increments, saturating at 255. The new flag is then set.
  - freeze=1: the capture is ignored, with no flag or count change.
- A read of DATA clears the new flag in its ACK cycle. If a capture lands in the same cycle, set wins: the flag stays 1 and the count does not increment. The read returns the pre-capture value latched in IDLE.
- Overrun clear and a simultaneous overrun increment in the same cycle: clear wins, count = 0.
- Reset values: Sl_DBus=0, Sl_xferAck=0, data_reg=0, flag=0, count=0, freeze=0, FSM in IDLE.
- Reset asserted mid-transaction aborts it with no ack; the master bus timeout handles recovery.

Optional Feature:
- Macro: OPB_S2P_SEQNUM_EN.
- Defined:
  - Offset 0x0C returns a 32-bit capture sequence number, reset to 0.
  - It increments, with wrap, on every accepted capture (freeze=0).
  - Software uses it to detect missed words.
- Undefined: 0x0C reads 0 and the counter logic is absent.

Decomposition:
- Package opb_s2p_pkg holds:
  - register offset constants (DATA, STATUS, CONTROL, SEQNUM);
  - STATUS and CONTROL bit-position constants;
  - the FSM state typedef (IDLE, ACK, DONE);
  - the overrun saturation constant (255).
- Sub-module opb_s2p_bus_fsm contains address decode, the three-state FSM, ack generation and Sl_DBus gating; it outputs rd_en/wr_en/offset strobes.
- The top level holds the capture registers and the read mux.

Test Plan:
- Reset, then read 0x00 and 0x04 -> both return 0x00000000; xferAck one cycle after select; Sl_DBus zero outside ack.
- user_data_valid with 0xDEADBEEF, then read 0x04 -> 0x00000001. Read 0x00 -> 0xDEADBEEF. Read 0x04 -> 0x00000000.
- Three valids (0x1, 0x2, 0x3) with no read -> STATUS = 0x00000201, DATA = 0x3. Write 0x08 = 0x2 -> STATUS = 0x00000001.
- 300 valids with no read -> count saturates, STATUS = 0x0000FF01.
- Write 0x08 = 0x1 (freeze), then valid 0xAAAA5555 -> DATA unchanged and flag unchanged. Read 0x08 -> 0x00000001.
- DATA read ack coincident with valid 0x12345678 -> returns old value, flag stays 1. Separately, select with an address outside the window -> no ack. With OPB_S2P_SEQNUM_EN, after 5 unfrozen captures 0x0C reads 0x00000005.
